// File: rtl/mem_responder_pkg.sv
// Shared definitions for the memory responder: parameter defaults, RV32 access
// size codes, FSM state encoding and the latched request record.
package mem_responder_pkg;

  localparam int DEFAULT_DEPTH_WORDS = 256;
  localparam int DEFAULT_WAIT_STATES = 1;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_RESP
  } state_t;

  typedef struct packed {
    logic        write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
  } req_t;

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane logic: alignment / funct3 legality, load lane extraction with
// sign or zero extension, and store lane merge into the addressed word.
module mem_lane_unit
  import mem_responder_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic        err,
  output logic [31:0] wr_word,
  output logic [31:0] ld_data
);

  logic [31:0] shifted;
  logic [31:0] lane_data;
  logic [3:0]  byte_en;

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    err       = 1'b0;
    byte_en   = 4'b0000;
    lane_data = wdata;
    ld_data   = '0;
    wr_word   = word;
    shifted   = word >> {offset, 3'b000};

    case (funct3)
      F3_B, F3_BU: begin
        byte_en   = 4'b0001 << offset;
        lane_data = {4{wdata[7:0]}};
        ld_data   = {{24{shifted[7] & ~funct3[2]}}, shifted[7:0]};
      end
      F3_H, F3_HU: begin
        err       = offset[0];
        byte_en   = offset[1] ? 4'b1100 : 4'b0011;
        lane_data = {2{wdata[15:0]}};
        ld_data   = {{16{shifted[15] & ~funct3[2]}}, shifted[15:0]};
      end
      F3_W: begin
        err     = (offset != 2'b00);
        byte_en = 4'b1111;
        ld_data = word;
      end
      default: err = 1'b1;
    endcase

    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) wr_word[8*i +: 8] = lane_data[8*i +: 8];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Single-port word memory behind a valid/ready request interface with a fixed
// number of wait states and a one-cycle, non-backpressured response pulse.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
  parameter int WAIT_STATES = DEFAULT_WAIT_STATES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int         IDX_W   = $clog2(DEPTH_WORDS);
  localparam logic [2:0] WS_LAST = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  state_t      state, state_next;
  logic [2:0]  cnt, cnt_next;
  logic        accept, commit, mem_we;
  req_t        req_in, req_q, req_cur;
  logic [31:0] rdata_q;
  logic        err_q;

  logic [31:0]      mem [DEPTH_WORDS];
  logic [IDX_W-1:0] idx;
  logic             lane_err;
  logic [31:0]      lane_wr_word, lane_ld_data;
  logic             unused_addr;

  assign req_in  = '{write: req_write, funct3: req_funct3, addr: req_addr, wdata: req_wdata};
  // Without wait states the request commits on its own acceptance edge.
  assign req_cur = (WAIT_STATES == 0) ? req_in : req_q;
  assign idx     = req_cur.addr[IDX_W+1:2];
  assign unused_addr = ^req_cur.addr[31:IDX_W+2];

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    accept     = 1'b0;
    commit     = 1'b0;
    case (state)
      ST_IDLE, ST_RESP: begin
        state_next = ST_IDLE;
        if (req_valid) begin
          accept   = 1'b1;
          cnt_next = 3'd0;
          if (WAIT_STATES == 0) begin
            state_next = ST_RESP;
            commit     = 1'b1;
          end else begin
            state_next = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (cnt == WS_LAST) begin
          state_next = ST_RESP;
          commit     = 1'b1;
          cnt_next   = 3'd0;
        end else begin
          cnt_next = cnt + 3'd1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= ST_IDLE;
      cnt     <= 3'd0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      state <= state_next;
      cnt   <= cnt_next;
      if (accept) req_q <= req_in;
      if (commit) begin
        err_q   <= lane_err;
        rdata_q <= (lane_err || req_cur.write) ? 32'd0 : lane_ld_data;
      end
    end
  end

  mem_lane_unit u_lane (
    .funct3  (req_cur.funct3),
    .offset  (req_cur.addr[1:0]),
    .wdata   (req_cur.wdata),
    .word    (mem[idx]),
    .err     (lane_err),
    .wr_word (lane_wr_word),
    .ld_data (lane_ld_data)
  );

  // A store accepted while reset is low must never reach the array.
  assign mem_we = commit && rst && req_cur.write && !lane_err;

  // NOTE: the storage array has no reset; only control state is cleared.
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx] <= lane_wr_word;
  end

  assign req_ready  = (state != ST_WAIT);
  assign resp_valid = (state == ST_RESP);
  assign resp_rdata = resp_valid ? rdata_q : 32'd0;
  assign resp_err   = resp_valid ? err_q : 1'b0;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: three instances (1, 0 and 3 wait states)
// share a request bus; a monitor pops expected responses as pulses appear.
module tb_mem_responder;
  import mem_responder_pkg::*;

  logic              clk;
  logic              rst;
  logic [2:0]        req_valid;
  logic [2:0]        req_ready;
  logic              req_write;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [2:0]        resp_valid;
  logic [31:0]       resp_rdata [3];
  logic [2:0]        resp_err;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;

  typedef struct {
    int          inst;
    logic [31:0] rdata;
    logic        err;
    int          due;
    string       name;
  } exp_t;

  exp_t sb[$];

  mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(1)) u_ws1 (
    .clk(clk), .rst(rst), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]),
    .resp_err(resp_err[0])
  );

  mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]),
    .resp_err(resp_err[1])
  );

  mem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid[2]), .resp_rdata(resp_rdata[2]),
    .resp_err(resp_err[2])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic int ws_of(input int inst);
    case (inst)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  // Called #1 after a rising edge; returns #1 after the acceptance edge.
  task automatic issue(input int inst, input logic w, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_err, input string name);
    int  waited = 0;
    bit  ok     = 0;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = a;
    req_wdata  = wd;
    req_valid  = '0;
    req_valid[inst] = 1'b1;
    while (!ok && waited < 20) begin
      @(negedge clk);
      if (req_ready[inst]) begin
        ok = 1;
        sb.push_back('{inst, exp_rd, exp_err, cyc + ws_of(inst) + 1, name});
      end else begin
        waited++;
      end
    end
    if (!ok) check({name, "_ready_timeout"}, 32'd0, 32'd1);
    @(posedge clk);
    #1 req_valid = '0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (resp_valid[k]) begin
          if (sb.size() == 0) begin
            check("unexpected_resp", 32'(k), 32'hFFFF_FFFF);
          end else begin
            e = sb.pop_front();
            check({e.name, "_inst"},  32'(k), 32'(e.inst));
            check({e.name, "_rdata"}, resp_rdata[k], e.rdata);
            check({e.name, "_err"},   32'(resp_err[k]), 32'(e.err));
            check({e.name, "_cycle"}, 32'(cyc), 32'(e.due));
          end
        end else if (resp_rdata[k] != 32'd0 || resp_err[k]) begin
          check("idle_outputs", resp_rdata[k] | 32'(resp_err[k]), 32'd0);
        end
      end
    end
  end

  initial begin
    int drain;
    rst        = 1'b0;
    req_valid  = '0;
    req_write  = 1'b0;
    req_funct3 = F3_W;
    req_addr   = '0;
    req_wdata  = '0;

    @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'd7);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1;

    // One wait state: word, byte, halfword and error paths.
    issue(0, 1'b1, F3_W,  32'h10, 32'hDEADBEEF, 32'h0,        1'b0, "sw_10");
    issue(0, 1'b0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, "lw_10");
    issue(0, 1'b0, F3_B,  32'h13, 32'h0,        32'hFFFFFFDE, 1'b0, "lb_13");
    issue(0, 1'b0, F3_BU, 32'h13, 32'h0,        32'h000000DE, 1'b0, "lbu_13");
    issue(0, 1'b0, F3_H,  32'h12, 32'h0,        32'hFFFFDEAD, 1'b0, "lh_12");
    issue(0, 1'b0, F3_HU, 32'h10, 32'h0,        32'h0000BEEF, 1'b0, "lhu_10");
    issue(0, 1'b1, F3_H,  32'h11, 32'h1234,     32'h0,        1'b1, "sh_mis_11");
    issue(0, 1'b0, F3_W,  32'h10, 32'h0,        32'hDEADBEEF, 1'b0, "lw_after_err");
    issue(0, 1'b0, F3_W,  32'h12, 32'h0,        32'h0,        1'b1, "lw_mis_12");
    issue(0, 1'b0, 3'b011, 32'h10, 32'h0,       32'h0,        1'b1, "f3_illegal");
    issue(0, 1'b1, F3_B,  32'h11, 32'hFFFFFFA5, 32'h0,        1'b0, "sb_11");
    issue(0, 1'b0, F3_W,  32'h10, 32'h0,        32'hDEADA5EF, 1'b0, "lw_after_sb");
    issue(0, 1'b1, F3_H,  32'h12, 32'h00001234, 32'h0,        1'b0, "sh_12");
    issue(0, 1'b0, F3_W,  32'h10, 32'h0,        32'h1234A5EF, 1'b0, "lw_after_sh");
    issue(0, 1'b1, F3_W,  32'h400, 32'h55,      32'h0,        1'b0, "sw_400");
    issue(0, 1'b0, F3_W,  32'h0,  32'h0,        32'h00000055, 1'b0, "lw_wrap_0");

    // Zero wait states: fill four words, then a back-to-back load burst.
    for (int i = 0; i < 4; i++)
      issue(1, 1'b1, F3_W, 32'(4 * i), 32'hC0DE_0000 + 32'(i), 32'h0, 1'b0, "ws0_fill");
    req_write  = 1'b0;
    req_funct3 = F3_W;
    req_valid  = 3'b010;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'(4 * i);
      @(negedge clk);
      check("b2b_ready", 32'(req_ready[1]), 32'd1);
      sb.push_back('{1, 32'hC0DE_0000 + 32'(i), 1'b0, cyc + 1, "b2b_lw"});
      @(posedge clk);
      #1;
    end
    req_valid = '0;

    // Three wait states: a store dropped by reset during WAIT must not commit.
    issue(2, 1'b1, F3_W, 32'h20, 32'h13579BDF, 32'h0, 1'b0, "ws3_sw_20");
    req_write  = 1'b1;
    req_funct3 = F3_W;
    req_addr   = 32'h20;
    req_wdata  = 32'hAAAAAAAA;
    drain = 0;
    while (req_ready[2] !== 1'b1 && drain < 20) begin
      @(posedge clk);
      #1 drain++;
    end
    req_valid = 3'b100;
    @(negedge clk);
    check("ws3_abort_accept_ready", 32'(req_ready[2]), 32'd1);
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("ws3_in_wait", 32'(req_ready[2]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_reset_ready", 32'(req_ready[2]), 32'd1);
    check("mid_reset_resp_valid", 32'(resp_valid[2]), 32'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    issue(2, 1'b0, F3_W, 32'h20, 32'h0, 32'h13579BDF, 1'b0, "ws3_lw_after_abort");

    drain = 0;
    while (sb.size() != 0 && drain < 50) begin
      @(posedge clk);
      drain++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
